// File: rtl/charge_request_scheduler_pkg.sv
// Shared definitions for the charge request scheduler: slot geometry,
// one-hot FSM state encoding and slot/coordinate helpers.
package bujin_sched_pkg;

   localparam int N_SLOT = 16;
   localparam int SLOT_W = 4;

   // One-hot state encoding; any other pattern is treated as illegal.
   typedef enum logic [4:0] {
      S_IDLE      = 5'b00001,
      S_ISSUE     = 5'b00010,
      S_WAIT_ACK  = 5'b00100,
      S_WAIT_DONE = 5'b01000,
      S_GAP       = 5'b10000
   } state_t;

   typedef struct packed {
      logic [1:0] y;
      logic [1:0] x;
   } xy_t;

   // Slot s sits at column s[1:0], row s[3:2] of the 4x4 grid.
   function automatic xy_t slot_to_xy(input logic [SLOT_W-1:0] slot);
      xy_t v_xy;
      v_xy.x = slot[1:0];
      v_xy.y = slot[3:2];
      return v_xy;
   endfunction

   // Single-bit mask selecting one slot in a request vector.
   function automatic logic [N_SLOT-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
      logic [N_SLOT-1:0] v_oh;
      v_oh = {{(N_SLOT-1){1'b0}}, 1'b1} << slot;
      return v_oh;
   endfunction

endpackage

// File: rtl/charge_request_scheduler_if.sv
// Bundle between the slot request logic, the scheduler and the
// coordinate controller. master = scheduler side, slave = environment.
interface charge_request_scheduler_if;
   import bujin_sched_pkg::*;

   logic [N_SLOT-1:0] req_pulse;
   logic              coord_enable;
   logic              coord_cmd_valid;
   logic [1:0]        target_x;
   logic [1:0]        target_y;
   logic [N_SLOT-1:0] pending;
   logic              busy;
   logic [SLOT_W-1:0] active_slot;
   logic              done_pulse;
   logic [SLOT_W-1:0] done_slot;
   logic              err_timeout;

   modport master (
      input  req_pulse, coord_enable,
      output coord_cmd_valid, target_x, target_y, pending, busy,
             active_slot, done_pulse, done_slot, err_timeout
   );

   modport slave (
      output req_pulse, coord_enable,
      input  coord_cmd_valid, target_x, target_y, pending, busy,
             active_slot, done_pulse, done_slot, err_timeout
   );

endinterface

// File: rtl/charge_request_scheduler_rr_arbiter.sv
// Combinational rotating priority encoder: picks the first set request
// at or after the pointer, wrapping from the top slot back to slot 0.
module rr_arbiter
   import bujin_sched_pkg::*;
(
   input  logic [N_SLOT-1:0] i_req,
   input  logic [SLOT_W-1:0] i_ptr,
   output logic [SLOT_W-1:0] o_grant,
   output logic              o_grant_valid
);

   logic [SLOT_W-1:0] w_idx;

   // Scan slots in rotated order; the first hit wins and later hits are ignored.
   always_comb begin
      o_grant       = {SLOT_W{1'b0}};
      o_grant_valid = 1'b0;
      w_idx         = {SLOT_W{1'b0}};
      for (int i = 0; i < N_SLOT; i++) begin
         w_idx = i_ptr + SLOT_W'(i);
         if (!o_grant_valid && i_req[w_idx]) begin
            o_grant       = w_idx;
            o_grant_valid = 1'b1;
         end else begin
            o_grant       = o_grant;
            o_grant_valid = o_grant_valid;
         end
      end
   end

endmodule

// File: rtl/charge_request_scheduler.sv
// Charge request scheduler: queues per-slot service requests, grants them
// round-robin and runs one coordinate-controller job at a time
// (issue, wait for the controller to go busy, wait for it to finish, settle).
module charge_request_scheduler
   import bujin_sched_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   charge_request_scheduler_if.master  io_sched
);

   localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam int GAP_W = (GAP_CYCLES  > 1) ? $clog2(GAP_CYCLES)  : 1;
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

   state_t            r_state;
   logic [N_SLOT-1:0] r_pending;
   logic [SLOT_W-1:0] r_rr_ptr;
   logic [SLOT_W-1:0] r_active_slot;
   logic [1:0]        r_target_x;
   logic [1:0]        r_target_y;
   logic              r_cmd_valid;
   logic              r_busy;
   logic              r_done_pulse;
   logic [SLOT_W-1:0] r_done_slot;
   logic              r_err_timeout;
   logic [ACK_W-1:0]  r_ack_cnt;
   logic [GAP_W-1:0]  r_gap_cnt;

   state_t            w_state_nxt;
   logic [N_SLOT-1:0] w_pending_nxt;
   logic [N_SLOT-1:0] w_grant_clear;
   logic [SLOT_W-1:0] w_rr_ptr_nxt;
   logic [SLOT_W-1:0] w_active_nxt;
   logic [1:0]        w_target_x_nxt;
   logic [1:0]        w_target_y_nxt;
   logic              w_cmd_valid_nxt;
   logic              w_done_pulse_nxt;
   logic [SLOT_W-1:0] w_done_slot_nxt;
   logic              w_err_timeout_nxt;
   logic [ACK_W-1:0]  w_ack_cnt_nxt;
   logic [GAP_W-1:0]  w_gap_cnt_nxt;
   logic [SLOT_W-1:0] w_grant;
   logic              w_grant_valid;
   xy_t               w_grant_xy;

   rr_arbiter u_rr_arbiter (
      .i_req         (r_pending),
      .i_ptr         (r_rr_ptr),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_valid)
   );

   assign w_grant_xy = slot_to_xy(w_grant);

   // Next-state and next-output logic; everything holds unless a state acts on it.
   always_comb begin
      w_state_nxt       = r_state;
      w_grant_clear     = {N_SLOT{1'b0}};
      w_rr_ptr_nxt      = r_rr_ptr;
      w_active_nxt      = r_active_slot;
      w_target_x_nxt    = r_target_x;
      w_target_y_nxt    = r_target_y;
      w_cmd_valid_nxt   = 1'b0;
      w_done_pulse_nxt  = 1'b0;
      w_done_slot_nxt   = r_done_slot;
      w_err_timeout_nxt = 1'b0;
      w_ack_cnt_nxt     = r_ack_cnt;
      w_gap_cnt_nxt     = r_gap_cnt;
      case (r_state)
         S_IDLE: begin
            // Do not start while the controller is busy on someone else's behalf.
            if (w_grant_valid && !io_sched.coord_enable) begin
               w_state_nxt     = S_ISSUE;
               w_active_nxt    = w_grant;
               w_target_x_nxt  = w_grant_xy.x;
               w_target_y_nxt  = w_grant_xy.y;
               w_grant_clear   = slot_onehot(w_grant);
               w_cmd_valid_nxt = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: begin
            w_ack_cnt_nxt = {ACK_W{1'b0}};
            w_state_nxt   = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            if (io_sched.coord_enable) begin
               w_state_nxt = S_WAIT_DONE;
            end else if (r_ack_cnt == ACK_LAST) begin
               // Controller never picked the command up: abandon it, no requeue.
               w_err_timeout_nxt = 1'b1;
               w_rr_ptr_nxt      = r_active_slot + 4'd1;
               w_gap_cnt_nxt     = {GAP_W{1'b0}};
               w_state_nxt       = S_GAP;
            end else begin
               w_ack_cnt_nxt = r_ack_cnt + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            // Jobs take tens of seconds; no watchdog here by design.
            if (!io_sched.coord_enable) begin
               w_done_pulse_nxt = 1'b1;
               w_done_slot_nxt  = r_active_slot;
               w_rr_ptr_nxt     = r_active_slot + 4'd1;
               w_gap_cnt_nxt    = {GAP_W{1'b0}};
               w_state_nxt      = S_GAP;
            end else begin
               w_state_nxt = S_WAIT_DONE;
            end
         end
         S_GAP: begin
            if (r_gap_cnt == GAP_LAST) begin
               w_gap_cnt_nxt = {GAP_W{1'b0}};
               w_state_nxt   = S_IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
      // A new request in the grant cycle survives the clear.
      w_pending_nxt = (r_pending & ~w_grant_clear) | io_sched.req_pulse;
   end

   // State and registered-output update; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_pending     <= {N_SLOT{1'b0}};
         r_rr_ptr      <= {SLOT_W{1'b0}};
         r_active_slot <= {SLOT_W{1'b0}};
         r_target_x    <= 2'd0;
         r_target_y    <= 2'd0;
         r_cmd_valid   <= 1'b0;
         r_busy        <= 1'b0;
         r_done_pulse  <= 1'b0;
         r_done_slot   <= {SLOT_W{1'b0}};
         r_err_timeout <= 1'b0;
         r_ack_cnt     <= {ACK_W{1'b0}};
         r_gap_cnt     <= {GAP_W{1'b0}};
      end else begin
         r_state       <= w_state_nxt;
         r_pending     <= w_pending_nxt;
         r_rr_ptr      <= w_rr_ptr_nxt;
         r_active_slot <= w_active_nxt;
         r_target_x    <= w_target_x_nxt;
         r_target_y    <= w_target_y_nxt;
         r_cmd_valid   <= w_cmd_valid_nxt;
         r_busy        <= (w_state_nxt != S_IDLE);
         r_done_pulse  <= w_done_pulse_nxt;
         r_done_slot   <= w_done_slot_nxt;
         r_err_timeout <= w_err_timeout_nxt;
         r_ack_cnt     <= w_ack_cnt_nxt;
         r_gap_cnt     <= w_gap_cnt_nxt;
      end
   end

   assign io_sched.coord_cmd_valid = r_cmd_valid;
   assign io_sched.target_x        = r_target_x;
   assign io_sched.target_y        = r_target_y;
   assign io_sched.pending         = r_pending;
   assign io_sched.busy            = r_busy;
   assign io_sched.active_slot     = r_active_slot;
   assign io_sched.done_pulse      = r_done_pulse;
   assign io_sched.done_slot       = r_done_slot;
   assign io_sched.err_timeout     = r_err_timeout;

endmodule

// File: tb/tb_charge_request_scheduler.sv
// Directed bench for charge_request_scheduler. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_charge_request_scheduler;
   import bujin_sched_pkg::*;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   cnt;

   charge_request_scheduler_if io ();

   charge_request_scheduler dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io_sched (io)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n           = 1'b0;
      io.req_pulse    = 16'h0000;
      io.coord_enable = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (io.busy !== 1'b0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_idle"}, 32'(n < 20), 32'd1);
   endtask

   // From the ISSUE cycle: acknowledge, run 3 busy cycles, release, check done.
   task automatic finish_job(input string tag, input logic [3:0] slot);
      int n;
      @(negedge clk);
      io.coord_enable = 1'b1;
      repeat (3) @(negedge clk);
      io.coord_enable = 1'b0;
      @(negedge clk);
      n = 0;
      while (io.done_pulse !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_done"}, 32'(n < 10), 32'd1);
      chk({tag, "_done_slot"}, 32'(io.done_slot), 32'(slot));
   endtask

   task automatic run_job(input string tag, input logic [3:0] slot);
      int n;
      n = 0;
      while (io.coord_cmd_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_issue"}, 32'(n < 40), 32'd1);
      chk({tag, "_slot"}, 32'(io.active_slot), 32'(slot));
      chk({tag, "_xy"}, 32'({io.target_y, io.target_x}), 32'(slot));
      finish_job(tag, slot);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst_n           = 1'b0;
      io.req_pulse    = 16'h0000;
      io.coord_enable = 1'b0;
      @(negedge clk);
      // Reset state
      chk("rst_valid", 32'(io.coord_cmd_valid), 32'd0);
      chk("rst_pending", 32'(io.pending), 32'd0);
      chk("rst_busy", 32'(io.busy), 32'd0);
      chk("rst_outs", 32'({io.target_x, io.target_y, io.active_slot, io.done_pulse,
                           io.done_slot, io.err_timeout}), 32'd0);
      do_reset();

      // Single request, slot 6: cycle t
      io.req_pulse = 16'h0040;
      chk("s6_t_valid", 32'(io.coord_cmd_valid), 32'd0);
      @(negedge clk);               // t+1
      io.req_pulse = 16'h0000;
      chk("s6_t1_pending", 32'(io.pending), 32'h0040);
      chk("s6_t1_valid", 32'(io.coord_cmd_valid), 32'd0);
      @(negedge clk);               // t+2
      chk("s6_t2_valid", 32'(io.coord_cmd_valid), 32'd1);
      chk("s6_t2_x", 32'(io.target_x), 32'd2);
      chk("s6_t2_y", 32'(io.target_y), 32'd1);
      chk("s6_t2_pending", 32'(io.pending), 32'h0000);
      chk("s6_t2_busy", 32'(io.busy), 32'd1);
      @(negedge clk);               // t+3
      io.coord_enable = 1'b1;
      chk("s6_t3_valid", 32'(io.coord_cmd_valid), 32'd0);
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (io.done_pulse === 1'b1 || io.coord_cmd_valid === 1'b1 ||
             io.target_x !== 2'd2 || io.target_y !== 2'd1) cnt++;
      end
      chk("s6_hold", 32'(cnt), 32'd0);
      io.coord_enable = 1'b0;
      @(negedge clk);               // first GAP cycle
      chk("s6_done", 32'(io.done_pulse), 32'd1);
      chk("s6_done_slot", 32'(io.done_slot), 32'd6);
      @(negedge clk);
      chk("s6_done_once", 32'(io.done_pulse), 32'd0);
      repeat (2) @(negedge clk);
      chk("s6_gap_busy", 32'(io.busy), 32'd1);
      @(negedge clk);
      chk("s6_idle_busy", 32'(io.busy), 32'd0);

      // Round-robin from pointer 0: 3, 9, 12, then 1, 3 with pointer at 13
      do_reset();
      io.req_pulse = 16'h1208;
      @(negedge clk);
      io.req_pulse = 16'h0000;
      chk("rr_pending", 32'(io.pending), 32'h1208);
      run_job("rr_a", 4'd3);
      run_job("rr_b", 4'd9);
      run_job("rr_c", 4'd12);
      io.req_pulse = 16'h000A;
      @(negedge clk);
      io.req_pulse = 16'h0000;
      run_job("rr_d", 4'd1);
      run_job("rr_e", 4'd3);

      // Ack timeout on slot 10 with slot 11 queued behind it
      wait_idle("to");
      io.req_pulse = 16'h0C00;      // c0
      @(negedge clk);
      io.req_pulse = 16'h0000;
      @(negedge clk);               // c2
      chk("to_issue", 32'(io.coord_cmd_valid), 32'd1);
      chk("to_slot", 32'(io.active_slot), 32'd10);
      repeat (16) @(negedge clk);   // c18
      chk("to_early", 32'(io.err_timeout), 32'd0);
      @(negedge clk);               // c19
      chk("to_err", 32'(io.err_timeout), 32'd1);
      chk("to_pending", 32'(io.pending), 32'h0800);
      @(negedge clk);
      chk("to_err_once", 32'(io.err_timeout), 32'd0);
      repeat (3) @(negedge clk);    // c23
      chk("to_next_wait", 32'(io.coord_cmd_valid), 32'd0);
      @(negedge clk);               // c24
      chk("to_next_issue", 32'(io.coord_cmd_valid), 32'd1);
      chk("to_next_slot", 32'(io.active_slot), 32'd11);
      finish_job("to_next", 4'd11);

      // Re-request of the active slot during WAIT_DONE
      wait_idle("rq");
      io.req_pulse = 16'h0020;
      @(negedge clk);
      io.req_pulse = 16'h0000;
      @(negedge clk);
      chk("rq_issue", 32'(io.coord_cmd_valid), 32'd1);
      @(negedge clk);
      io.coord_enable = 1'b1;
      @(negedge clk);
      io.req_pulse = 16'h0020;
      @(negedge clk);
      io.req_pulse = 16'h0000;
      chk("rq_pending", 32'(io.pending), 32'h0020);
      io.coord_enable = 1'b0;
      @(negedge clk);
      chk("rq_done", 32'(io.done_pulse), 32'd1);
      chk("rq_done_slot", 32'(io.done_slot), 32'd5);
      run_job("rq_again", 4'd5);

      // Controller busy from elsewhere while slot 2 waits
      wait_idle("eb");
      io.coord_enable = 1'b1;
      io.req_pulse    = 16'h0004;
      @(negedge clk);
      io.req_pulse = 16'h0000;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (io.coord_cmd_valid === 1'b1 || io.busy === 1'b1) cnt++;
      end
      chk("eb_held", 32'(cnt), 32'd0);
      chk("eb_pending", 32'(io.pending), 32'h0004);
      io.coord_enable = 1'b0;
      @(negedge clk);
      chk("eb_issue", 32'(io.coord_cmd_valid), 32'd1);
      chk("eb_slot", 32'(io.active_slot), 32'd2);
      finish_job("eb", 4'd2);

      // Reset in the middle of a job (slot 4) with slots 0 and 7 pending
      wait_idle("mr");
      io.req_pulse = 16'h0010;
      @(negedge clk);
      io.req_pulse = 16'h0000;
      @(negedge clk);
      chk("mr_issue", 32'(io.coord_cmd_valid), 32'd1);
      @(negedge clk);
      io.coord_enable = 1'b1;
      @(negedge clk);
      io.req_pulse = 16'h0081;
      @(negedge clk);
      io.req_pulse = 16'h0000;
      chk("mr_pre_pending", 32'(io.pending), 32'h0081);
      chk("mr_pre_busy", 32'(io.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_pending", 32'(io.pending), 32'd0);
      chk("mr_busy", 32'(io.busy), 32'd0);
      chk("mr_outs", 32'({io.coord_cmd_valid, io.target_x, io.target_y, io.active_slot,
                          io.done_pulse, io.done_slot, io.err_timeout}), 32'd0);
      @(negedge clk);
      io.coord_enable = 1'b0;
      rst_n = 1'b1;
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (io.coord_cmd_valid === 1'b1 || io.busy === 1'b1 || io.pending !== 16'h0000) cnt++;
      end
      chk("mr_quiet", 32'(cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
